// File: rtl/jtag_pkg.sv
// Shared JTAG debug-transport types: AXI status encoding and the AXI master FSM states.
package jtag_pkg;

    typedef enum logic [2:0] {
        AXI_ST_IDLE    = 3'd0,
        AXI_ST_RUNNING = 3'd1,
        AXI_ST_OKAY    = 3'd2,
        AXI_ST_EXOKAY  = 3'd3,
        AXI_ST_SLVERR  = 3'd4,
        AXI_ST_DECERR  = 3'd5,
        AXI_ST_TIMEOUT = 3'd6
    } jtag_axi_status_t;

    typedef enum logic [2:0] {
        AXI_FSM_IDLE,
        AXI_FSM_WR_REQ,
        AXI_FSM_WR_RESP,
        AXI_FSM_RD_REQ,
        AXI_FSM_RD_RESP
    } jtag_axi_fsm_t;

    // AXI xRESP values map onto the completed-status codes with a fixed offset of 2.
    function automatic jtag_axi_status_t axi_resp_to_status(input logic [1:0] resp);
        return jtag_axi_status_t'({1'b0, resp} + 3'd2);
    endfunction

endpackage

// File: rtl/jtag_axi_master_ctrl.sv
// Single-outstanding AXI4 master driven by JTAG DR requests, clocked by tck.
// Optional busy-timeout status enabled by defining JTAG_AXI_TIMEOUT_EN.
module jtag_axi_master_ctrl
    import jtag_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                    tck,
    input  logic                    trst,
    input  logic                    txn_start,
    input  logic                    txn_wr,
    input  logic [ADDR_WIDTH-1:0]   txn_addr,
    input  logic [DATA_WIDTH-1:0]   txn_wdata,
    input  logic [DATA_WIDTH/8-1:0] txn_wstrb,
    input  logic [2:0]              txn_size,
    output logic                    busy,
    output logic [2:0]              txn_status,
    output logic [DATA_WIDTH-1:0]   txn_rdata,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [2:0]              awsize,
    output logic                    wvalid,
    input  logic                    wready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    input  logic                    bvalid,
    output logic                    bready,
    input  logic [1:0]              bresp,
    output logic                    arvalid,
    input  logic                    arready,
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic [2:0]              arsize,
    input  logic                    rvalid,
    output logic                    rready,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast
);

    jtag_axi_fsm_t          state_q;
    jtag_axi_status_t       status_q;
    logic                   busy_q;
    logic                   awvalid_q, wvalid_q, arvalid_q, bready_q, rready_q;
    logic                   aw_acc_q, w_acc_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [DATA_WIDTH/8-1:0] wstrb_q;
    logic [2:0]             size_q;
    logic [DATA_WIDTH-1:0]  rdata_q;

    logic aw_hs, w_hs, aw_done, w_done, timed_out;

    assign aw_hs   = awvalid_q & awready;
    assign w_hs    = wvalid_q & wready;
    assign aw_done = aw_acc_q | aw_hs;
    assign w_done  = w_acc_q | w_hs;

    logic unused_rlast;
    assign unused_rlast = rlast;

`ifdef JTAG_AXI_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             to_hit;

    assign to_hit    = busy_q && (cnt_q == CNT_MAX);
    assign timed_out = (status_q == AXI_ST_TIMEOUT);
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge tck) begin
        if (trst) begin
            state_q   <= AXI_FSM_IDLE;
            status_q  <= AXI_ST_IDLE;
            busy_q    <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            rready_q  <= 1'b0;
            aw_acc_q  <= 1'b0;
            w_acc_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            size_q    <= '0;
            rdata_q   <= '0;
`ifdef JTAG_AXI_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            case (state_q)
                AXI_FSM_IDLE: begin
                    if (txn_start) begin
                        addr_q   <= txn_addr;
                        wdata_q  <= txn_wdata;
                        wstrb_q  <= txn_wstrb;
                        size_q   <= txn_size;
                        status_q <= AXI_ST_RUNNING;
                        busy_q   <= 1'b1;
                        if (txn_wr) begin
                            state_q   <= AXI_FSM_WR_REQ;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            aw_acc_q  <= 1'b0;
                            w_acc_q   <= 1'b0;
                        end else begin
                            state_q   <= AXI_FSM_RD_REQ;
                            arvalid_q <= 1'b1;
                        end
                    end
                end
                // AW and W complete independently; leave once both have been taken.
                AXI_FSM_WR_REQ: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_acc_q  <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_acc_q  <= 1'b1;
                    end
                    if (aw_done && w_done) begin
                        state_q  <= AXI_FSM_WR_RESP;
                        bready_q <= 1'b1;
                    end
                end
                AXI_FSM_WR_RESP: begin
                    if (bvalid) begin
                        bready_q <= 1'b0;
                        busy_q   <= 1'b0;
                        state_q  <= AXI_FSM_IDLE;
                        if (!timed_out) status_q <= axi_resp_to_status(bresp);
                    end
                end
                AXI_FSM_RD_REQ: begin
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= AXI_FSM_RD_RESP;
                    end
                end
                AXI_FSM_RD_RESP: begin
                    if (rvalid) begin
                        rready_q <= 1'b0;
                        busy_q   <= 1'b0;
                        rdata_q  <= rdata;
                        state_q  <= AXI_FSM_IDLE;
                        if (!timed_out) status_q <= axi_resp_to_status(rresp);
                    end
                end
                default: state_q <= AXI_FSM_IDLE;
            endcase
`ifdef JTAG_AXI_TIMEOUT_EN
            // Saturating busy counter; TIMEOUT overrides any completion in the same cycle.
            if (state_q == AXI_FSM_IDLE) begin
                if (txn_start) cnt_q <= '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (to_hit) status_q <= AXI_ST_TIMEOUT;
`endif
        end
    end

    assign busy       = busy_q;
    assign txn_status = status_q;
    assign txn_rdata  = rdata_q;
    assign awvalid    = awvalid_q;
    assign awaddr     = addr_q;
    assign awsize     = size_q;
    assign wvalid     = wvalid_q;
    assign wdata      = wdata_q;
    assign wstrb      = wstrb_q;
    assign wlast      = 1'b1;
    assign bready     = bready_q;
    assign arvalid    = arvalid_q;
    assign araddr     = addr_q;
    assign arsize     = size_q;
    assign rready     = rready_q;

endmodule

// File: tb/tb_jtag_axi_master_ctrl.sv
// Directed bench for jtag_axi_master_ctrl; timeout section follows JTAG_AXI_TIMEOUT_EN.
module tb_jtag_axi_master_ctrl;

    logic        tck = 1'b0;
    logic        trst;
    logic        txn_start, txn_wr;
    logic [31:0] txn_addr, txn_wdata;
    logic [3:0]  txn_wstrb;
    logic [2:0]  txn_size;
    logic        busy;
    logic [2:0]  txn_status;
    logic [31:0] txn_rdata;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awsize, arsize;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        arvalid, arready, rvalid, rready, rlast;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 tck = ~tck;

    jtag_axi_master_ctrl #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .tck(tck), .trst(trst),
        .txn_start(txn_start), .txn_wr(txn_wr), .txn_addr(txn_addr),
        .txn_wdata(txn_wdata), .txn_wstrb(txn_wstrb), .txn_size(txn_size),
        .busy(busy), .txn_status(txn_status), .txn_rdata(txn_rdata),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awsize(awsize),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arsize(arsize),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge tck);
        #1;
    endtask

    task automatic start(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        txn_start = 1'b1;
        txn_wr    = wr;
        txn_addr  = addr;
        txn_wdata = data;
        txn_wstrb = 4'hF;
        txn_size  = 3'd2;
    endtask

    initial begin
        trst = 1'b1; txn_start = 0; txn_wr = 0; txn_addr = '0; txn_wdata = '0;
        txn_wstrb = '0; txn_size = '0; awready = 0; wready = 0; bvalid = 0;
        bresp = '0; arready = 0; rvalid = 0; rdata = '0; rresp = '0; rlast = 1'b1;
        tick(); tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_status", 32'(txn_status), 32'd0);
        chk("rst_rdata", txn_rdata, 32'd0);
        chk("rst_valids", 32'({awvalid, wvalid, arvalid, bready, rready}), 32'd0);
        trst = 1'b0;
        tick();

        // Zero-wait write OKAY
        awready = 1; wready = 1;
        start(1'b1, 32'h1000_0004, 32'hDEAD_BEEF);
        tick(); txn_start = 0;
        chk("w1_awvalid", 32'(awvalid), 32'd1);
        chk("w1_wvalid", 32'(wvalid), 32'd1);
        chk("w1_awaddr", awaddr, 32'h1000_0004);
        chk("w1_wdata", wdata, 32'hDEAD_BEEF);
        chk("w1_wstrb", 32'(wstrb), 32'hF);
        chk("w1_wlast", 32'(wlast), 32'd1);
        chk("w1_awsize", 32'(awsize), 32'd2);
        chk("w1_running", 32'(txn_status), 32'd1);
        chk("w1_busy", 32'(busy), 32'd1);
        bvalid = 1; bresp = 2'd0;
        tick();
        chk("w2_valids", 32'({awvalid, wvalid}), 32'd0);
        chk("w2_bready", 32'(bready), 32'd1);
        tick(); bvalid = 0; awready = 0; wready = 0;
        chk("w3_status", 32'(txn_status), 32'd2);
        chk("w3_busy", 32'(busy), 32'd0);
        chk("w3_bready", 32'(bready), 32'd0);

        // Split write: AW taken at cycle 1, W at cycle 4, SLVERR
        awready = 1;
        start(1'b1, 32'h3000_0000, 32'h0000_00AA);
        tick(); txn_start = 0;
        chk("s1_both", 32'({awvalid, wvalid}), 32'd3);
        tick(); awready = 0;
        chk("s2_aw", 32'(awvalid), 32'd0);
        chk("s2_w", 32'(wvalid), 32'd1);
        chk("s2_bready", 32'(bready), 32'd0);
        tick();
        chk("s3_w", 32'(wvalid), 32'd1);
        tick();
        chk("s4_w", 32'(wvalid), 32'd1);
        chk("s4_aw", 32'(awvalid), 32'd0);
        wready = 1;
        tick(); wready = 0;
        chk("s5_w", 32'(wvalid), 32'd0);
        chk("s5_bready", 32'(bready), 32'd1);
        bvalid = 1; bresp = 2'd2;
        tick(); bvalid = 0;
        chk("s6_status", 32'(txn_status), 32'd4);
        chk("s6_busy", 32'(busy), 32'd0);

        // Read with delayed arready, DECERR; a second start mid-read must be ignored
        start(1'b0, 32'h2000_0000, 32'h0);
        tick(); txn_start = 0;
        chk("r1_arvalid", 32'(arvalid), 32'd1);
        chk("r1_araddr", araddr, 32'h2000_0000);
        chk("r1_awvalid", 32'(awvalid), 32'd0);
        tick();
        start(1'b0, 32'hFFFF_FFF0, 32'h0);
        tick(); txn_start = 0;
        chk("r3_araddr", araddr, 32'h2000_0000);
        chk("r3_arvalid", 32'(arvalid), 32'd1);
        tick(); arready = 1;
        tick(); arready = 0;
        chk("r5_arvalid", 32'(arvalid), 32'd0);
        chk("r5_rready", 32'(rready), 32'd1);
        rvalid = 1; rdata = 32'h1234_5678; rresp = 2'd3;
        tick(); rvalid = 0;
        chk("r6_rdata", txn_rdata, 32'h1234_5678);
        chk("r6_status", 32'(txn_status), 32'd5);
        chk("r6_busy", 32'(busy), 32'd0);
        tick();
        chk("r7_no_rearm", 32'(arvalid), 32'd0);
        chk("r7_araddr", araddr, 32'h2000_0000);

        // Reset while awvalid is high
        start(1'b1, 32'h4000_0000, 32'h5555_5555);
        tick(); txn_start = 0;
        chk("x1_awvalid", 32'(awvalid), 32'd1);
        trst = 1;
        tick(); trst = 0;
        chk("x2_valids", 32'({awvalid, wvalid, arvalid, bready, rready}), 32'd0);
        chk("x2_busy", 32'(busy), 32'd0);
        chk("x2_status", 32'(txn_status), 32'd0);
        chk("x2_rdata", txn_rdata, 32'd0);

        // Best-case read after reset
        arready = 1;
        start(1'b0, 32'h5000_0010, 32'h0);
        tick(); txn_start = 0;
        chk("b1_arvalid", 32'(arvalid), 32'd1);
        tick(); arready = 0;
        chk("b2_rready", 32'(rready), 32'd1);
        rvalid = 1; rdata = 32'hA5A5_5A5A; rresp = 2'd1;
        tick(); rvalid = 0;
        chk("b3_rdata", txn_rdata, 32'hA5A5_5A5A);
        chk("b3_status", 32'(txn_status), 32'd3);
        chk("b3_busy", 32'(busy), 32'd0);

        // arready held low for 20 cycles
        start(1'b0, 32'h6000_0000, 32'h0);
        tick(); txn_start = 0;
        for (int c = 2; c <= 16; c++) tick();
        chk("t16_status", 32'(txn_status), 32'd1);
        tick();
`ifdef JTAG_AXI_TIMEOUT_EN
        chk("t17_status", 32'(txn_status), 32'd6);
`else
        chk("t17_status", 32'(txn_status), 32'd1);
`endif
        chk("t17_busy", 32'(busy), 32'd1);
        chk("t17_arvalid", 32'(arvalid), 32'd1);
        for (int c = 18; c <= 20; c++) tick();
        arready = 1;
        tick(); arready = 0;
        chk("t21_rready", 32'(rready), 32'd1);
        rvalid = 1; rdata = 32'hCAFE_F00D; rresp = 2'd0;
        tick(); rvalid = 0;
        chk("t22_busy", 32'(busy), 32'd0);
        chk("t22_rdata", txn_rdata, 32'hCAFE_F00D);
`ifdef JTAG_AXI_TIMEOUT_EN
        chk("t22_status", 32'(txn_status), 32'd6);
`else
        chk("t22_status", 32'(txn_status), 32'd2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
